mc_front_end_v2: RTL and testbench



---
 rtl/mc_front_end_v2.sv | 221 ++++++++++++++++++++++
 tb/tb_mc_front_end_v2.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_front_end_v2.sv
// mc_front_end_v2: memory-controller front end.
// Decodes the target bank of each RNIC request, queues it in a per-bank FIFO
// toward the bank schedulers, tags reads with a reorder-buffer (ROB) index and
// returns read data to the RNIC strictly in request order.
// Optional macro FE_BANK_HASH_EN: when defined, the bank is the XOR of the
// bank field with the next-higher field of the same width, which spreads
// strided traffic across banks. The packet always carries the raw address.
module mc_front_end_v2 #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 26,
  parameter int BANKS      = 16,
  parameter int BANK_LSB   = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int ROB_DEPTH  = 128,
  parameter int BANK_BITS  = $clog2(BANKS),
  parameter int IDX_W      = $clog2(ROB_DEPTH),
  parameter int REQ_W      = 1 + IDX_W + ADDR_W + DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_request_type,
  input  logic [DATA_W-1:0]      in_request_data,
  input  logic [ADDR_W-1:0]      in_request_address,
  output logic                   out_busy,
  input  logic                   request_done_valid,
  input  logic                   the_type,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [IDX_W-1:0]       index,
  output logic                   write_done,
  output logic                   read_done,
  output logic [DATA_W-1:0]      data_out,
  output logic [BANKS*REQ_W-1:0] out,
  output logic [BANKS-1:0]       valid_o,
  input  logic [BANKS-1:0]       ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE      = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0] CNT_ONE      = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W:0] ROB_FULL_CNT = (IDX_W+1)'(ROB_DEPTH);

  typedef logic [REQ_W-1:0] pkt_t;

  // Bank FIFO storage; pointers carry one extra wrap bit to tell full from empty.
  pkt_t             fifo_mem_r    [BANKS][FIFO_DEPTH];
  logic [PTR_W:0]   fifo_wr_ptr_r [BANKS];
  logic [PTR_W:0]   fifo_rd_ptr_r [BANKS];
  logic [BANKS-1:0] fifo_full_s;
  logic [BANKS-1:0] fifo_empty_s;
  logic [BANKS-1:0] push_s;
  logic [BANKS-1:0] pop_s;

  // Request path.
  logic [BANK_BITS-1:0] bank_s;
  logic                 busy_s;
  logic                 accept_s;
  logic                 alloc_s;
  pkt_t                 new_pkt_s;

  // Reorder buffer: pending marks an allocated slot, done marks completed data.
  logic [ROB_DEPTH-1:0] rob_pend_r;
  logic [ROB_DEPTH-1:0] rob_done_r;
  logic [DATA_W-1:0]    rob_data_r [ROB_DEPTH];
  logic [IDX_W-1:0]     rob_head_r;
  logic [IDX_W-1:0]     rob_tail_r;
  logic [IDX_W:0]       rob_count_r;
  logic                 rob_full_s;
  logic                 retire_s;
  logic                 cmp_ok_s;

  // Registered response outputs.
  logic              read_done_r;
  logic              write_done_r;
  logic [DATA_W-1:0] data_out_r;

  // Per-bank FIFO full/empty flags from registered pointers only (no bypass).
  always_comb begin
    fifo_full_s  = {BANKS{1'b0}};
    fifo_empty_s = {BANKS{1'b1}};
    for (int b = 0; b < BANKS; b++) begin
      fifo_empty_s[b] = (fifo_wr_ptr_r[b] == fifo_rd_ptr_r[b]);
      fifo_full_s[b]  = (fifo_wr_ptr_r[b][PTR_W] != fifo_rd_ptr_r[b][PTR_W]) &&
                        (fifo_wr_ptr_r[b][PTR_W-1:0] == fifo_rd_ptr_r[b][PTR_W-1:0]);
    end
  end

  // Bank decode, busy/accept decision, push/pop strobes and the new packet.
  always_comb begin
`ifdef FE_BANK_HASH_EN
    bank_s = in_request_address[BANK_LSB +: BANK_BITS] ^
             in_request_address[BANK_LSB + BANK_BITS +: BANK_BITS];
`else
    bank_s = in_request_address[BANK_LSB +: BANK_BITS];
`endif
    rob_full_s = (rob_count_r == ROB_FULL_CNT);
    if (in_valid) begin
      busy_s = fifo_full_s[bank_s] | (~in_request_type & rob_full_s);
    end else begin
      busy_s = rob_full_s;
    end
    accept_s = in_valid & ~busy_s;
    alloc_s  = accept_s & ~in_request_type;
    push_s   = {BANKS{1'b0}};
    pop_s    = {BANKS{1'b0}};
    for (int b = 0; b < BANKS; b++) begin
      push_s[b] = accept_s & (bank_s == BANK_BITS'(b));
      pop_s[b]  = ~fifo_empty_s[b] & ready[b];
    end
    if (in_request_type) begin
      new_pkt_s = {1'b1, {IDX_W{1'b0}}, in_request_address, in_request_data};
    end else begin
      new_pkt_s = {1'b0, rob_tail_r, in_request_address, {DATA_W{1'b0}}};
    end
  end

  // ROB retire and completion qualification.
  always_comb begin
    retire_s = (rob_count_r != {(IDX_W+1){1'b0}}) & rob_done_r[rob_head_r];
    cmp_ok_s = request_done_valid & ~the_type & rob_pend_r[index] & ~rob_done_r[index];
  end

  // Present each FIFO head to its bank scheduler.
  always_comb begin
    out     = {(BANKS*REQ_W){1'b0}};
    valid_o = {BANKS{1'b0}};
    for (int b = 0; b < BANKS; b++) begin
      valid_o[b]              = ~fifo_empty_s[b];
      out[b*REQ_W +: REQ_W]   = fifo_mem_r[b][fifo_rd_ptr_r[b][PTR_W-1:0]];
    end
  end

  // FIFO pointer advance; a push and a pop in one cycle leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        fifo_wr_ptr_r[b] <= {(PTR_W+1){1'b0}};
        fifo_rd_ptr_r[b] <= {(PTR_W+1){1'b0}};
      end
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (push_s[b]) begin
          fifo_wr_ptr_r[b] <= fifo_wr_ptr_r[b] + PTR_ONE;
        end
        if (pop_s[b]) begin
          fifo_rd_ptr_r[b] <= fifo_rd_ptr_r[b] + PTR_ONE;
        end
      end
    end
  end

  // FIFO payload write; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      fifo_mem_r[bank_s][fifo_wr_ptr_r[bank_s][PTR_W-1:0]] <= new_pkt_s;
    end
  end

  // ROB bookkeeping: allocate at tail, retire at head, mark completions done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rob_pend_r  <= {ROB_DEPTH{1'b0}};
      rob_done_r  <= {ROB_DEPTH{1'b0}};
      rob_head_r  <= {IDX_W{1'b0}};
      rob_tail_r  <= {IDX_W{1'b0}};
      rob_count_r <= {(IDX_W+1){1'b0}};
    end else begin
      // Head and tail never coincide while both an allocate and a retire
      // happen: that needs a full ROB, which blocks reads.
      if (alloc_s) begin
        rob_pend_r[rob_tail_r] <= 1'b1;
        rob_done_r[rob_tail_r] <= 1'b0;
        rob_tail_r             <= rob_tail_r + IDX_ONE;
      end
      if (retire_s) begin
        rob_pend_r[rob_head_r] <= 1'b0;
        rob_done_r[rob_head_r] <= 1'b0;
        rob_head_r             <= rob_head_r + IDX_ONE;
      end
      // A completion only targets a slot that is pending and not yet done,
      // so it can never collide with the slot being allocated or retired.
      if (cmp_ok_s) begin
        rob_done_r[index] <= 1'b1;
      end
      case ({alloc_s, retire_s})
        2'b10:   rob_count_r <= rob_count_r + CNT_ONE;
        2'b01:   rob_count_r <= rob_count_r - CNT_ONE;
        default: rob_count_r <= rob_count_r;
      endcase
    end
  end

  // ROB read data capture; qualified by the done flags, so no reset.
  always_ff @(posedge clk) begin
    if (cmp_ok_s) begin
      rob_data_r[index] <= data_in;
    end
  end

  // Registered completion pulses and in-order read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read_done_r  <= 1'b0;
      write_done_r <= 1'b0;
      data_out_r   <= {DATA_W{1'b0}};
    end else begin
      read_done_r  <= retire_s;
      write_done_r <= request_done_valid & the_type;
      if (retire_s) begin
        data_out_r <= rob_data_r[rob_head_r];
      end
    end
  end

  assign out_busy   = busy_s;
  assign read_done  = read_done_r;
  assign write_done = write_done_r;
  assign data_out   = data_out_r;

endmodule

// File: tb/tb_mc_front_end_v2.sv
// Testbench for mc_front_end_v2: directed scenarios followed by a random phase,
// all checked every cycle against a queue-based behavioural model.
module tb_mc_front_end_v2;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 26;
  localparam int BANKS      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int ROB_DEPTH  = 128;
  localparam int IDX_W      = 7;
  localparam int REQ_W      = 1 + IDX_W + ADDR_W + DATA_W;
  localparam int OW         = BANKS * REQ_W;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_request_type = 1'b0;
  logic [DATA_W-1:0]      in_request_data = '0;
  logic [ADDR_W-1:0]      in_request_address = '0;
  logic                   out_busy;
  logic                   request_done_valid = 1'b0;
  logic                   the_type = 1'b0;
  logic [DATA_W-1:0]      data_in = '0;
  logic [IDX_W-1:0]       index = '0;
  logic                   write_done;
  logic                   read_done;
  logic [DATA_W-1:0]      data_out;
  logic [OW-1:0]          out;
  logic [BANKS-1:0]       valid_o;
  logic [BANKS-1:0]       ready = '0;

  mc_front_end_v2 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_request_type(in_request_type),
    .in_request_data(in_request_data), .in_request_address(in_request_address),
    .out_busy(out_busy),
    .request_done_valid(request_done_valid), .the_type(the_type),
    .data_in(data_in), .index(index),
    .write_done(write_done), .read_done(read_done), .data_out(data_out),
    .out(out), .valid_o(valid_o), .ready(ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: one queue of packets per bank, an ordered list of
  // outstanding read indices, and per-index completion flags/data.
  logic [REQ_W-1:0]  bq [BANKS][$];
  int                rob_q [$];
  bit                pend_f [ROB_DEPTH];
  bit                done_f [ROB_DEPTH];
  logic [DATA_W-1:0] done_d [ROB_DEPTH];
  int                next_idx = 0;
  logic              exp_rd = 1'b0;
  logic              exp_wd = 1'b0;
  logic [DATA_W-1:0] exp_do = '0;
  bit                model_ok = 1'b0;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_bank(input logic [ADDR_W-1:0] a);
    int lo;
    lo = int'(a) % BANKS;
`ifdef FE_BANK_HASH_EN
    return lo ^ ((int'(a) / BANKS) % BANKS);
`else
    return lo;
`endif
  endfunction

  task automatic model_reset();
    for (int b = 0; b < BANKS; b++) bq[b].delete();
    rob_q.delete();
    for (int i = 0; i < ROB_DEPTH; i++) begin
      pend_f[i] = 1'b0;
      done_f[i] = 1'b0;
    end
    next_idx = 0;
    exp_rd   = 1'b0;
    exp_wd   = 1'b0;
    exp_do   = '0;
  endtask

  // One clock: check combinational/head state, predict the edge, check registered outputs.
  task automatic cycle();
    int            bk;
    int            hidx;
    bit            eb, acc, ret, cok;
    bit            popf [BANKS];
    logic [OW-1:0] eo, mask;
    logic [BANKS-1:0] ev;
    logic [REQ_W-1:0] pkt;
    #1;
    bk = model_bank(in_request_address);
    if (in_valid) eb = (bq[bk].size() == FIFO_DEPTH) || (!in_request_type && rob_q.size() == ROB_DEPTH);
    else          eb = (rob_q.size() == ROB_DEPTH);
    if (model_ok) begin
      eo = '0; mask = '0; ev = '0;
      for (int b = 0; b < BANKS; b++) begin
        if (bq[b].size() > 0) begin
          ev[b] = 1'b1;
          eo[b*REQ_W +: REQ_W]   = bq[b][0];
          mask[b*REQ_W +: REQ_W] = {REQ_W{1'b1}};
        end
      end
      check("out_busy", OW'(out_busy), OW'(eb));
      check("valid_o", OW'(valid_o), OW'(ev));
      check("out_head", out & mask, eo);
    end
    acc = in_valid && !eb;
    ret = (rob_q.size() > 0) && done_f[rob_q[0]];
    cok = request_done_valid && !the_type && pend_f[index] && !done_f[index];
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      model_ok = 1'b1;
    end else begin
      for (int b = 0; b < BANKS; b++) popf[b] = ready[b] && (bq[b].size() > 0);
      for (int b = 0; b < BANKS; b++) if (popf[b]) void'(bq[b].pop_front());
      if (acc) begin
        if (in_request_type) begin
          pkt = {1'b1, 7'd0, in_request_address, in_request_data};
        end else begin
          pkt = {1'b0, 7'(next_idx), in_request_address, in_request_data};
          rob_q.push_back(next_idx);
          pend_f[next_idx] = 1'b1;
          next_idx = (next_idx + 1) % ROB_DEPTH;
        end
        bq[bk].push_back(pkt);
      end
      if (ret) begin
        hidx = rob_q.pop_front();
        exp_rd = 1'b1;
        exp_do = done_d[hidx];
        pend_f[hidx] = 1'b0;
        done_f[hidx] = 1'b0;
      end else begin
        exp_rd = 1'b0;
      end
      if (cok) begin
        done_f[index] = 1'b1;
        done_d[index] = data_in;
      end
      exp_wd = request_done_valid && the_type;
    end
    #1;
    if (model_ok) begin
      check("read_done", OW'(read_done), OW'(exp_rd));
      check("data_out", OW'(data_out), OW'(exp_do));
      check("write_done", OW'(write_done), OW'(exp_wd));
    end
  endtask

  task automatic expect_busy(input string tag, input logic e);
    #1;
    check(tag, OW'(out_busy), OW'(e));
  endtask

  task automatic set_req(input logic v, input logic t, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = v; in_request_type = t; in_request_address = a; in_request_data = d;
  endtask

  task automatic set_cmp(input logic v, input logic t, input logic [IDX_W-1:0] i, input logic [DATA_W-1:0] d);
    request_done_valid = v; the_type = t; index = i; data_in = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, '0, '0);
    set_cmp(1'b0, 1'b0, '0, '0);
    cycle();
    rst_n = 1'b1;
  endtask

  logic [DATA_W-1:0] got [$];
  int hb;

  initial begin
    // Reset then idle.
    do_reset();
    do_reset();
    ready = '0;
    for (int i = 0; i < 3; i++) cycle();
    check("reset_data_out", OW'(data_out), OW'(16'h0000));

    // FIFO full backpressure on bank 3.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      set_req(1'b1, 1'b1, 26'h3, DATA_W'(16'h1000 + i));
      cycle();
    end
    set_req(1'b1, 1'b1, 26'h3, 16'h5555);
    expect_busy("fifo_full_busy", 1'b1);
    cycle();
    ready[3] = 1'b1;
    expect_busy("no_bypass_busy", 1'b1);
    cycle();
    ready[3] = 1'b0;
    expect_busy("after_pop_accept", 1'b0);
    cycle();
    set_req(1'b0, 1'b0, '0, '0);
    ready = '1;
    for (int i = 0; i < 6; i++) cycle();

    // Out-of-order read completion, in-order return.
    set_req(1'b1, 1'b0, 26'h10, 16'h0); cycle();
    set_req(1'b1, 1'b0, 26'h21, 16'h0); cycle();
    set_req(1'b1, 1'b0, 26'h32, 16'h0); cycle();
    set_req(1'b0, 1'b0, '0, '0);
    set_cmp(1'b1, 1'b0, 7'd2, 16'hCCCC); cycle();
    set_cmp(1'b1, 1'b0, 7'd1, 16'hBBBB); cycle();
    set_cmp(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("no_early_read_done", OW'(read_done), OW'(1'b0));
    end
    set_cmp(1'b1, 1'b0, 7'd0, 16'hAAAA); cycle();
    set_cmp(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (read_done) got.push_back(data_out);
    end
    check("ooo_count", OW'(got.size()), OW'(3));
    check("ooo_first", OW'(got[0]), OW'(16'hAAAA));
    check("ooo_second", OW'(got[1]), OW'(16'hBBBB));
    check("ooo_third", OW'(got[2]), OW'(16'hCCCC));

    // ROB full with schedulers draining every bank.
    do_reset();
    ready = '1;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      set_req(1'b1, 1'b0, ADDR_W'(i), 16'h0);
      cycle();
    end
    set_req(1'b1, 1'b0, 26'h9, 16'h0);
    expect_busy("rob_full_read_busy", 1'b1);
    cycle();
    set_req(1'b1, 1'b1, 26'h5, 16'h5A5A);
    expect_busy("rob_full_write_ok", 1'b0);
    cycle();
    set_req(1'b0, 1'b0, '0, '0);
    set_cmp(1'b1, 1'b0, 7'd0, 16'h1234); cycle();
    set_cmp(1'b0, 1'b0, '0, '0); cycle();
    set_req(1'b1, 1'b0, 26'h7, 16'h0);
    expect_busy("rob_wrap_accept", 1'b0);
    cycle();
    set_req(1'b0, 1'b0, '0, '0);
    check("rob_wrap_idx", OW'(out[7*REQ_W + DATA_W + ADDR_W +: IDX_W]), OW'(7'd0));
    cycle();

    // Reset in the middle of 128 outstanding reads: nothing is returned.
    set_cmp(1'b1, 1'b0, 7'd5, 16'h7777);
    do_reset();
    set_cmp(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) cycle();

    // Coincident write completion and read retire; allocate with retire.
    ready = '1;
    set_req(1'b1, 1'b0, 26'h0, 16'h0); cycle();
    set_req(1'b0, 1'b0, '0, '0);
    set_cmp(1'b1, 1'b0, 7'd0, 16'hBEEF); cycle();
    set_cmp(1'b1, 1'b1, 7'd0, 16'h0);
    set_req(1'b1, 1'b0, 26'h1, 16'h0);
    cycle();
    check("coinc_write_done", OW'(write_done), OW'(1'b1));
    check("coinc_read_done", OW'(read_done), OW'(1'b1));
    check("coinc_data", OW'(data_out), OW'(16'hBEEF));
    check("alloc_retire_count", OW'(dut.rob_count_r), OW'(1));
    set_req(1'b0, 1'b0, '0, '0);
    set_cmp(1'b0, 1'b0, '0, '0);
    cycle();

    // Bank decode of address 0x015.
    do_reset();
    ready = '0;
`ifdef FE_BANK_HASH_EN
    hb = 4;
`else
    hb = 5;
`endif
    set_req(1'b1, 1'b1, 26'h015, 16'h0F0F); cycle();
    set_req(1'b0, 1'b0, '0, '0);
    check("bank_decode", OW'(valid_o), OW'(16'h0001 << hb));
    cycle();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      in_valid           = ($urandom_range(0, 9) < 6);
      in_request_type    = 1'($urandom_range(0, 1));
      in_request_address = ADDR_W'($urandom);
      in_request_data    = in_request_type ? DATA_W'($urandom) : '0;
      ready              = BANKS'($urandom);
      request_done_valid = 1'($urandom_range(0, 1));
      the_type           = ($urandom_range(0, 3) == 0);
      if (rob_q.size() > 0 && $urandom_range(0, 4) != 0)
        index = 7'(rob_q[$urandom_range(0, rob_q.size() - 1)]);
      else
        index = 7'($urandom);
      data_in = DATA_W'($urandom);
      cycle();
    end
    set_req(1'b0, 1'b0, '0, '0);
    set_cmp(1'b0, 1'b0, '0, '0);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
